edge_event_arbiter: RTL and testbench

- Multi-channel edge-event collector.
- Per channel: synchronise an asynchronous input, detect rising and falling edges, and hold them as sticky pending events.
- A round-robin scheduler serialises all pending events onto one valid/ready event stream.
- Sits between slow external pins (GPIO/IRQ lines) and a single event consumer (interrupt controller or event FIFO). The clock must oversample the inputs.

---
 rtl/edge_evt_pkg.sv | 25 ++
 rtl/edge_evt_chan.sv | 105 ++++++++++
 rtl/edge_event_arbiter.sv | 137 +++++++++++++
 tb/tb_edge_event_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event arbiter.
// Optional timestamp support is enabled with EDGE_EVT_TIMESTAMP_EN.
package edge_evt_pkg;

   // Container widths sized for the largest supported configuration.
   localparam int unsigned EvtChanWMax = 5;
   localparam int unsigned EvtTsWMax   = 64;

   typedef enum logic {
      FALL = 1'b0,
      RISE = 1'b1
   } edge_e;

   typedef struct packed {
      logic [EvtChanWMax-1:0] chan;
      edge_e                  kind;
      logic [EvtTsWMax-1:0]   ts;
   } evt_t;

   // Pointer reset value: the last channel, so channel 0 is searched first.
   function automatic int unsigned rr_ptr_rst(input int unsigned num_chan);
      return num_chan - 1;
   endfunction

endpackage

// File: rtl/edge_evt_chan.sv
// One channel: synchroniser, edge detector, sticky rise/fall pending bits,
// age order bit, overflow flag and (with EDGE_EVT_TIMESTAMP_EN) stamps.
module edge_evt_chan
   import edge_evt_pkg::*;
#(
   parameter int unsigned SyncStages = 2
`ifdef EDGE_EVT_TIMESTAMP_EN
   , parameter int unsigned TsWidth = 16
`endif
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               d_i,
   input  logic               deq_rise_i,
   input  logic               deq_fall_i,
   input  logic               ovf_clr_i,
`ifdef EDGE_EVT_TIMESTAMP_EN
   input  logic [TsWidth-1:0] ts_i,
   output logic [TsWidth-1:0] rise_ts_o,
   output logic [TsWidth-1:0] fall_ts_o,
`endif
   output logic               rise_pend_o,
   output logic               fall_pend_o,
   output logic               rise_first_o,
   output logic               ovf_o
);

   logic [SyncStages-1:0] sync_d, sync_q;
   logic prev_d, prev_q;
   logic rise_pls_d, rise_pls_q, fall_pls_d, fall_pls_q;
   logic rise_pend_d, rise_pend_q, fall_pend_d, fall_pend_q;
   logic rise_first_d, rise_first_q;
   logic ovf_d, ovf_q;
   logic lvl, rise_keep, fall_keep;
`ifdef EDGE_EVT_TIMESTAMP_EN
   logic [TsWidth-1:0] rise_ts_d, rise_ts_q, fall_ts_d, fall_ts_q;
`endif

   always_comb begin
      lvl          = sync_q[SyncStages-1];
      sync_d       = {sync_q[SyncStages-2:0], d_i};
      prev_d       = lvl;
      rise_pls_d   = lvl & ~prev_q & en_i;
      fall_pls_d   = ~lvl & prev_q & en_i;
      rise_keep    = rise_pend_q & ~deq_rise_i;
      fall_keep    = fall_pend_q & ~deq_fall_i;
      rise_pend_d  = rise_keep | rise_pls_q;
      fall_pend_d  = fall_keep | fall_pls_q;
      // A surviving lone pending type is older than anything arriving now.
      rise_first_d = rise_first_q;
      if (rise_keep && !fall_keep) begin
         rise_first_d = 1'b1;
      end else if (fall_keep && !rise_keep) begin
         rise_first_d = 1'b0;
      end else if (!rise_keep && !fall_keep) begin
         rise_first_d = rise_pls_q;
      end
      ovf_d = (rise_pls_q & rise_keep) | (fall_pls_q & fall_keep) | (ovf_q & ~ovf_clr_i);
`ifdef EDGE_EVT_TIMESTAMP_EN
      rise_ts_d = (rise_pls_q && !rise_keep) ? ts_i : rise_ts_q;
      fall_ts_d = (fall_pls_q && !fall_keep) ? ts_i : fall_ts_q;
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q       <= '0;
         prev_q       <= 1'b0;
         rise_pls_q   <= 1'b0;
         fall_pls_q   <= 1'b0;
         rise_pend_q  <= 1'b0;
         fall_pend_q  <= 1'b0;
         rise_first_q <= 1'b0;
         ovf_q        <= 1'b0;
`ifdef EDGE_EVT_TIMESTAMP_EN
         rise_ts_q    <= '0;
         fall_ts_q    <= '0;
`endif
      end else begin
         sync_q       <= sync_d;
         prev_q       <= prev_d;
         rise_pls_q   <= rise_pls_d;
         fall_pls_q   <= fall_pls_d;
         rise_pend_q  <= rise_pend_d;
         fall_pend_q  <= fall_pend_d;
         rise_first_q <= rise_first_d;
         ovf_q        <= ovf_d;
`ifdef EDGE_EVT_TIMESTAMP_EN
         rise_ts_q    <= rise_ts_d;
         fall_ts_q    <= fall_ts_d;
`endif
      end
   end

   assign rise_pend_o  = rise_pend_q;
   assign fall_pend_o  = fall_pend_q;
   assign rise_first_o = rise_first_q;
   assign ovf_o        = ovf_q;
`ifdef EDGE_EVT_TIMESTAMP_EN
   assign rise_ts_o    = rise_ts_q;
   assign fall_ts_o    = fall_ts_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event collector with a round-robin valid/ready output.
// Define EDGE_EVT_TIMESTAMP_EN to add detection timestamps (evt_ts_o).
module edge_event_arbiter
   import edge_evt_pkg::*;
#(
   parameter  int unsigned NumChan    = 4,
   parameter  int unsigned SyncStages = 2,
   parameter  int unsigned TsWidth    = 16,
   localparam int unsigned ChanW      = (NumChan > 1) ? $clog2(NumChan) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NumChan-1:0] en_i,
   input  logic [NumChan-1:0] d_i,
   output logic               evt_valid_o,
   input  logic               evt_ready_i,
   output logic [ChanW-1:0]   evt_chan_o,
   output logic               evt_rise_o,
   output logic [NumChan-1:0] ovf_o,
`ifdef EDGE_EVT_TIMESTAMP_EN
   output logic [TsWidth-1:0] evt_ts_o,
`endif
   input  logic               ovf_clr_i
);

   localparam logic [ChanW-1:0] PtrRst = ChanW'(rr_ptr_rst(NumChan));

   logic [NumChan-1:0] rise_pend, fall_pend, rise_first, deq_rise, deq_fall;
   logic               valid_d, valid_q;
   logic [ChanW-1:0]   ptr_d, ptr_q, gnt_idx, cand;
   logic               load, found, gnt_rise;
   evt_t               evt_d, evt_q;
   logic               unused_evt_bits;
`ifdef EDGE_EVT_TIMESTAMP_EN
   logic [TsWidth-1:0] ts_cnt_d, ts_cnt_q, gnt_ts;
   logic [TsWidth-1:0] rise_ts [NumChan];
   logic [TsWidth-1:0] fall_ts [NumChan];
`endif

   for (genvar c = 0; c < NumChan; c++) begin : g_chan
      edge_evt_chan #(
         .SyncStages (SyncStages)
`ifdef EDGE_EVT_TIMESTAMP_EN
         , .TsWidth  (TsWidth)
`endif
      ) u_chan (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .en_i         (en_i[c]),
         .d_i          (d_i[c]),
         .deq_rise_i   (deq_rise[c]),
         .deq_fall_i   (deq_fall[c]),
         .ovf_clr_i    (ovf_clr_i),
`ifdef EDGE_EVT_TIMESTAMP_EN
         .ts_i         (ts_cnt_q),
         .rise_ts_o    (rise_ts[c]),
         .fall_ts_o    (fall_ts[c]),
`endif
         .rise_pend_o  (rise_pend[c]),
         .fall_pend_o  (fall_pend[c]),
         .rise_first_o (rise_first[c]),
         .ovf_o        (ovf_o[c])
      );
   end

   // Round-robin search from ptr+1 with wrap, then output-register load.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int unsigned i = 1; i <= NumChan; i++) begin
         cand = ChanW'((32'(ptr_q) + i) % NumChan);
         if (!found && (rise_pend[cand] || fall_pend[cand])) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_rise = rise_pend[gnt_idx] && (!fall_pend[gnt_idx] || rise_first[gnt_idx]);
`ifdef EDGE_EVT_TIMESTAMP_EN
      gnt_ts   = gnt_rise ? rise_ts[gnt_idx] : fall_ts[gnt_idx];
      ts_cnt_d = ts_cnt_q + TsWidth'(1);
`endif

      load     = !valid_q || evt_ready_i;
      valid_d  = valid_q;
      ptr_d    = ptr_q;
      evt_d    = evt_q;
      deq_rise = '0;
      deq_fall = '0;
      if (load) begin
         valid_d = found;
         if (found) begin
            ptr_d      = gnt_idx;
            evt_d.chan = EvtChanWMax'(gnt_idx);
            evt_d.kind = gnt_rise ? RISE : FALL;
`ifdef EDGE_EVT_TIMESTAMP_EN
            evt_d.ts   = EvtTsWMax'(gnt_ts);
`else
            evt_d.ts   = '0;
`endif
            if (gnt_rise) begin
               deq_rise[gnt_idx] = 1'b1;
            end else begin
               deq_fall[gnt_idx] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         ptr_q    <= PtrRst;
         evt_q    <= '0;
`ifdef EDGE_EVT_TIMESTAMP_EN
         ts_cnt_q <= '0;
`endif
      end else begin
         valid_q  <= valid_d;
         ptr_q    <= ptr_d;
         evt_q    <= evt_d;
`ifdef EDGE_EVT_TIMESTAMP_EN
         ts_cnt_q <= ts_cnt_d;
`endif
      end
   end

   assign evt_valid_o     = valid_q;
   assign evt_chan_o      = evt_q.chan[ChanW-1:0];
   assign evt_rise_o      = (evt_q.kind == RISE);
`ifdef EDGE_EVT_TIMESTAMP_EN
   assign evt_ts_o        = evt_q.ts[TsWidth-1:0];
`endif
   // The event container is wider than this configuration needs.
   assign unused_evt_bits = ^evt_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (default configuration).
module tb_edge_event_arbiter;

   logic       clk = 1'b0;
   logic       rst_i;
   logic [3:0] en_i;
   logic [3:0] d_i;
   logic       evt_ready_i;
   logic       ovf_clr_i;
   logic       evt_valid_o;
   logic [1:0] evt_chan_o;
   logic       evt_rise_o;
   logic [3:0] ovf_o;
`ifdef EDGE_EVT_TIMESTAMP_EN
   logic [15:0] evt_ts_o;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   edge_event_arbiter #(
      .NumChan    (4),
      .SyncStages (2),
      .TsWidth    (16)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .d_i         (d_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_chan_o  (evt_chan_o),
      .evt_rise_o  (evt_rise_o),
      .ovf_o       (ovf_o),
`ifdef EDGE_EVT_TIMESTAMP_EN
      .evt_ts_o    (evt_ts_o),
`endif
      .ovf_clr_i   (ovf_clr_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (evt_valid_o) break;
         tick();
      end
      chk(tag, 32'(evt_valid_o), 32'd1);
   endtask

   task automatic chk_evt(input string tag, input logic [1:0] chan, input logic rise);
      chk({tag, "_valid"}, 32'(evt_valid_o), 32'd1);
      chk({tag, "_chan"}, 32'(evt_chan_o), 32'(chan));
      chk({tag, "_rise"}, 32'(evt_rise_o), 32'(rise));
   endtask

   initial begin
      logic quiet;
      logic stable;
      rst_i       = 1'b1;
      en_i        = 4'hF;
      d_i         = 4'h0;
      evt_ready_i = 1'b1;
      ovf_clr_i   = 1'b0;
      ticks(3);
      chk("rst_valid", 32'(evt_valid_o), 32'd0);
      chk("rst_chan", 32'(evt_chan_o), 32'd0);
      chk("rst_rise", 32'(evt_rise_o), 32'd0);
      chk("rst_ovf", 32'(ovf_o), 32'd0);
      rst_i = 1'b0;
      ticks(6);
      chk("idle_valid", 32'(evt_valid_o), 32'd0);

      // Contention: channels 0, 1, 3 rise together, then fall together.
      d_i = 4'b1011;
      wait_valid("burst1_wait");
      chk_evt("burst1_e0", 2'd0, 1'b1);
      tick();
      chk_evt("burst1_e1", 2'd1, 1'b1);
      tick();
      chk_evt("burst1_e2", 2'd3, 1'b1);
      tick();
      chk("burst1_done", 32'(evt_valid_o), 32'd0);
      d_i = 4'b0000;
      wait_valid("burst2_wait");
      chk_evt("burst2_e0", 2'd0, 1'b0);
      tick();
      chk_evt("burst2_e1", 2'd1, 1'b0);
      tick();
      chk_evt("burst2_e2", 2'd3, 1'b0);
      tick();
      chk("burst2_done", 32'(evt_valid_o), 32'd0);

      // Single edge on channel 2: valid exactly 4 edges after first sample.
      d_i[2] = 1'b1;
      ticks(4);
      chk("lat_edge3_valid", 32'(evt_valid_o), 32'd0);
      tick();
      chk_evt("lat_edge4", 2'd2, 1'b1);
      tick();
      chk("lat_done", 32'(evt_valid_o), 32'd0);
      d_i[2] = 1'b0;
      wait_valid("fall2_wait");
      chk_evt("fall2", 2'd2, 1'b0);
      tick();
      chk("fall2_done", 32'(evt_valid_o), 32'd0);

      // Backpressure: held event stays stable, then the queue drains.
      evt_ready_i = 1'b0;
      d_i = 4'b0011;
      wait_valid("bp_wait");
      chk_evt("bp_first", 2'd0, 1'b1);
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!(evt_valid_o && evt_chan_o == 2'd0 && evt_rise_o)) stable = 1'b0;
      end
      chk("bp_hold_stable", 32'(stable), 32'd1);
      evt_ready_i = 1'b1;
      tick();
      chk_evt("bp_drain1", 2'd1, 1'b1);
      tick();
      chk("bp_done", 32'(evt_valid_o), 32'd0);
      d_i = 4'b0000;
      wait_valid("bp_fall_wait");
      chk_evt("bp_fall0", 2'd0, 1'b0);
      tick();
      chk_evt("bp_fall1", 2'd1, 1'b0);
      tick();
      chk("bp_fall_done", 32'(evt_valid_o), 32'd0);

      // Overflow: output occupied, channel 1 rises, falls, rises again.
      evt_ready_i = 1'b0;
      d_i[0] = 1'b1;
      wait_valid("ovf_occ_wait");
      chk_evt("ovf_occ", 2'd0, 1'b1);
      d_i[1] = 1'b1;
      ticks(6);
      d_i[1] = 1'b0;
      ticks(6);
      d_i[1] = 1'b1;
      ticks(6);
      chk("ovf_set", 32'(ovf_o), 32'h2);
      chk_evt("ovf_held", 2'd0, 1'b1);
      evt_ready_i = 1'b1;
      tick();
      chk_evt("ovf_drain_rise", 2'd1, 1'b1);
      tick();
      chk_evt("ovf_drain_fall", 2'd1, 1'b0);
      tick();
      chk("ovf_drain_done", 32'(evt_valid_o), 32'd0);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("ovf_cleared", 32'(ovf_o), 32'h0);

      // Clear coinciding with a new overflow: the set wins.
      evt_ready_i = 1'b0;
      d_i[1] = 1'b0;
      wait_valid("coin_occ_wait");
      chk_evt("coin_occ", 2'd1, 1'b0);
      ticks(6);
      d_i[1] = 1'b1;
      ticks(6);
      d_i[1] = 1'b0;
      ticks(6);
      d_i[1] = 1'b1;
      ticks(3);
      chk("coin_pre", 32'(ovf_o), 32'h0);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      chk("coin_set_wins", 32'(ovf_o), 32'h2);

      // Reset with a held event and several pending events.
      d_i = 4'b1010;
      ticks(6);
      chk_evt("prerst_held", 2'd1, 1'b0);
      rst_i = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(evt_valid_o), 32'd0);
      chk("rst_mid_ovf", 32'(ovf_o), 32'h0);
      evt_ready_i = 1'b1;
      ticks(2);
      rst_i = 1'b0;
      wait_valid("postrst_wait");
      chk_evt("postrst_e0", 2'd1, 1'b1);
      tick();
      chk_evt("postrst_e1", 2'd3, 1'b1);
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (evt_valid_o) quiet = 1'b0;
      end
      chk("postrst_no_stale", 32'(quiet), 32'd1);

      // Enable: toggles on a disabled channel are ignored, re-enable is quiet.
      en_i = 4'hE;
      quiet = 1'b1;
      d_i[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin tick(); if (evt_valid_o) quiet = 1'b0; end
      d_i[0] = 1'b0;
      for (int i = 0; i < 6; i++) begin tick(); if (evt_valid_o) quiet = 1'b0; end
      d_i[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin tick(); if (evt_valid_o) quiet = 1'b0; end
      chk("en_off_quiet", 32'(quiet), 32'd1);
      en_i = 4'hF;
      quiet = 1'b1;
      for (int i = 0; i < 8; i++) begin tick(); if (evt_valid_o) quiet = 1'b0; end
      chk("en_on_no_spurious", 32'(quiet), 32'd1);
      d_i[0] = 1'b0;
      wait_valid("en_on_wait");
      chk_evt("en_on_fall", 2'd0, 1'b0);
      tick();
      chk("en_on_done", 32'(evt_valid_o), 32'd0);
      chk("final_ovf", 32'(ovf_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
